// File: rtl/sdio_timeout_timer.sv
// sdio_timeout_timer: times SDIO response, busy and read-data windows in
// sd_clk cycles. Optional prescaler, one-shot or periodic reload, hold
// input, sticky timeout flag and a visible count.
//
// Ports:
//   sd_clk, rst      clock and synchronous active-high reset
//   cnt_en           run request; low aborts and returns to IDLE (flag kept)
//   cnt_hold         freezes count and prescaler while running
//   cnt_sel          upper bits of the terminal count, sampled on start
//   cnt_mode         0 = one-shot, 1 = periodic, sampled on start
//   prescale         divide value minus one, sampled on start
//   timeout_clr      clears timeout_flag (a terminal step in the same cycle wins)
//   timeout_event    one-cycle pulse per terminal count
//   timeout_flag     sticky timeout indication
//   busy             high while in RUN
//   cnt_val          current count
//
// Build option: define SDIO_TIMER_PRESC_EN to include the prescaler. Without
// it the counter advances on every unheld cycle and prescale is ignored.
module sdio_timeout_timer #(
    parameter int SEL_W   = 8,
    parameter int LOW_W   = 18,
    parameter int PRESC_W = 4
) (
    input  logic                     sd_clk,
    input  logic                     rst,
    input  logic                     cnt_en,
    input  logic                     cnt_hold,
    input  logic [SEL_W-1:0]         cnt_sel,
    input  logic                     cnt_mode,
    input  logic [PRESC_W-1:0]       prescale,
    input  logic                     timeout_clr,
    output logic                     timeout_event,
    output logic                     timeout_flag,
    output logic                     busy,
    output logic [SEL_W+LOW_W-1:0]   cnt_val
);

    localparam int CNT_W = SEL_W + LOW_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic               mode_q, mode_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   cnt_max;
    logic               event_nxt;
    logic               flag_nxt;
    logic               adv;

`ifdef SDIO_TIMER_PRESC_EN
    logic [PRESC_W-1:0] presc_q, presc_nxt;
    logic [PRESC_W-1:0] pcnt, pcnt_nxt;

    assign adv = !cnt_hold && (pcnt == presc_q);
`else
    // prescale is kept on the port for drop-in compatibility only
    logic unused_prescale;
    assign unused_prescale = ^prescale;

    assign adv = !cnt_hold;
`endif

    // Terminal count: selected upper bits over an all-ones low field
    assign cnt_max = {sel_q, {LOW_W{1'b1}}};
    assign cnt_val = cnt;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        mode_nxt  = mode_q;
        cnt_nxt   = cnt;
        event_nxt = 1'b0;
        flag_nxt  = timeout_flag && !timeout_clr;
`ifdef SDIO_TIMER_PRESC_EN
        presc_nxt = presc_q;
        pcnt_nxt  = pcnt;
`endif
        case (state)
            IDLE: begin
                if (cnt_en) begin
                    state_nxt = RUN;
                    sel_nxt   = cnt_sel;
                    mode_nxt  = cnt_mode;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b0;
`ifdef SDIO_TIMER_PRESC_EN
                    presc_nxt = prescale;
                    pcnt_nxt  = '0;
`endif
                end
            end
            RUN: begin
                if (!cnt_en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
`ifdef SDIO_TIMER_PRESC_EN
                    pcnt_nxt  = '0;
`endif
                end else begin
`ifdef SDIO_TIMER_PRESC_EN
                    if (!cnt_hold) begin
                        pcnt_nxt = adv ? '0 : pcnt + PRESC_W'(1);
                    end
`endif
                    if (adv) begin
                        if (cnt == cnt_max) begin
                            // terminal step overrides a coincident clear
                            event_nxt = 1'b1;
                            flag_nxt  = 1'b1;
                            if (mode_q) begin
                                cnt_nxt = '0;
                            end else begin
                                state_nxt = DONE;
                            end
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!cnt_en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
`ifdef SDIO_TIMER_PRESC_EN
                    pcnt_nxt  = '0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            mode_q        <= 1'b0;
            cnt           <= '0;
            timeout_event <= 1'b0;
            timeout_flag  <= 1'b0;
            busy          <= 1'b0;
`ifdef SDIO_TIMER_PRESC_EN
            presc_q       <= '0;
            pcnt          <= '0;
`endif
        end else begin
            state         <= state_nxt;
            sel_q         <= sel_nxt;
            mode_q        <= mode_nxt;
            cnt           <= cnt_nxt;
            timeout_event <= event_nxt;
            timeout_flag  <= flag_nxt;
            busy          <= (state_nxt == RUN);
`ifdef SDIO_TIMER_PRESC_EN
            presc_q       <= presc_nxt;
            pcnt          <= pcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sdio_timeout_timer.sv
// Bench for sdio_timeout_timer: directed scenarios followed by random
// stimulus, checked against a behavioural model based on elapsed unheld
// cycles; expected timeout events are queued and matched by a monitor.
module tb_sdio_timeout_timer;

    localparam int SEL_W   = 2;
    localparam int LOW_W   = 2;
    localparam int PRESC_W = 2;
    localparam int CNT_W   = SEL_W + LOW_W;
`ifdef SDIO_TIMER_PRESC_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif

    logic               sd_clk = 1'b0;
    logic               rst = 1'b1;
    logic               cnt_en = 1'b0;
    logic               cnt_hold = 1'b0;
    logic [SEL_W-1:0]   cnt_sel = '0;
    logic               cnt_mode = 1'b0;
    logic [PRESC_W-1:0] prescale = '0;
    logic               timeout_clr = 1'b0;
    logic               timeout_event;
    logic               timeout_flag;
    logic               busy;
    logic [CNT_W-1:0]   cnt_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    bit mon_on = 1'b0;

    // reference model state
    bit m_run = 0, m_done = 0, m_flag = 0;
    int m_active = 0, m_cmax = 0, m_p = 1, m_cnt = 0;
    bit m_mode = 0;

    always #5 sd_clk = ~sd_clk;

    sdio_timeout_timer #(.SEL_W(SEL_W), .LOW_W(LOW_W), .PRESC_W(PRESC_W)) dut (
        .sd_clk        (sd_clk),
        .rst           (rst),
        .cnt_en        (cnt_en),
        .cnt_hold      (cnt_hold),
        .cnt_sel       (cnt_sel),
        .cnt_mode      (cnt_mode),
        .prescale      (prescale),
        .timeout_clr   (timeout_clr),
        .timeout_event (timeout_event),
        .timeout_flag  (timeout_flag),
        .busy          (busy),
        .cnt_val       (cnt_val)
    );

    function automatic int eff_p(input int pv);
        return PRESC_ON ? pv + 1 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Model: count stays (elapsed unheld cycles / divider) mod (cnt_max+1);
    // a terminal step happens whenever elapsed cycles hit a whole period.
    task automatic model_step();
        int period;
        bit term;
        term = 1'b0;
        cyc++;
        if (rst) begin
            m_run = 0; m_done = 0; m_flag = 0; m_cnt = 0;
        end else if (!cnt_en) begin
            m_run = 0; m_done = 0; m_cnt = 0;
            if (timeout_clr) m_flag = 0;
        end else if (!m_run && !m_done) begin
            m_cmax   = (int'(cnt_sel) << LOW_W) + (1 << LOW_W) - 1;
            m_mode   = cnt_mode;
            m_p      = eff_p(int'(prescale));
            m_active = 0;
            m_run    = 1;
            m_cnt    = 0;
            m_flag   = 0;
        end else if (m_run) begin
            if (!cnt_hold) begin
                m_active++;
                period = (m_cmax + 1) * m_p;
                if (m_active % period == 0) begin
                    term = 1'b1;
                    exp_q.push_back(cyc);
                    m_flag = 1;
                    if (m_mode) begin
                        m_cnt = 0;
                    end else begin
                        m_run = 0; m_done = 1; m_cnt = m_cmax;
                    end
                end else begin
                    m_cnt = (m_active / m_p) % (m_cmax + 1);
                end
            end
            if (timeout_clr && !term) m_flag = 0;
        end else begin
            if (timeout_clr) m_flag = 0;
        end
    endtask

    initial forever begin
        @(posedge sd_clk);
        model_step();
    end

    // Monitor: state compare every cycle, events popped from the queue
    initial forever begin
        @(negedge sd_clk);
        if (mon_on) begin
            check("cnt_val", 32'(cnt_val), 32'(m_cnt));
            check("busy", 32'(busy), 32'(m_run));
            check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                checks++; errors++;
                $display("FAIL missing_event cyc=%0d actual=none required=event@%0d", cyc, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (timeout_event === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d actual=1 required=0", cyc);
                end else if (exp_q[0] != cyc) begin
                    errors++;
                    $display("FAIL event_time cyc=%0d actual=%0d required=%0d", cyc, cyc, exp_q[0]);
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (timeout_event !== 1'b0) begin
                checks++; errors++;
                $display("FAIL event_x cyc=%0d actual=%b required=0", cyc, timeout_event);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sd_clk);
    endtask

    // Call right after raising cnt_en at a negedge; the start edge is the next
    // posedge and the event should be visible lat edges after it.
    task automatic expect_latency(input string name, input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < lat + 20 && !seen; i++) begin
            @(negedge sd_clk);
            n++;
            if (timeout_event === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != lat + 1) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (seen=%0b)", name, n, lat + 1, seen);
        end
    endtask

    initial begin
        tick(1);
        mon_on = 1'b1;
        tick(2);
        check("reset_cnt", 32'(cnt_val), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);

        // one-shot, cnt_max=3
        cnt_sel = '0; prescale = '0; cnt_mode = 1'b0; cnt_en = 1'b1;
        expect_latency("oneshot_latency", 4 * eff_p(0));
        tick(20);
        check("oneshot_saturate", 32'(cnt_val), 32'd3);
        check("oneshot_flag", 32'(timeout_flag), 32'd1);
        cnt_en = 1'b0; tick(2);

        // periodic, prescale=1; later input changes must be ignored
        cnt_mode = 1'b1; prescale = 2'd1; cnt_en = 1'b1;
        expect_latency("periodic_latency", 4 * eff_p(1));
        tick(20);
        cnt_sel = 2'd3; cnt_mode = 1'b0; prescale = 2'd3;
        tick(20);
        cnt_en = 1'b0; tick(2);

        // hold for 3 cycles mid-run
        cnt_sel = '0; cnt_mode = 1'b0; prescale = '0; cnt_en = 1'b1;
        tick(2); cnt_hold = 1'b1; tick(3); cnt_hold = 1'b0;
        tick(12);
        cnt_en = 1'b0; tick(2);

        // abort at cnt=2, restart with cnt_max=7
        cnt_en = 1'b1; tick(3);
        check("abort_point", 32'(cnt_val), 32'd2);
        cnt_en = 1'b0; tick(1);
        check("abort_idle_cnt", 32'(cnt_val), 32'd0);
        cnt_sel = 2'd1; cnt_en = 1'b1;
        expect_latency("restart_latency", 8 * eff_p(0));
        tick(5);
        cnt_en = 1'b0; tick(2);

        // clear coincident with terminal step, then clear alone
        cnt_sel = '0; cnt_mode = 1'b0; cnt_en = 1'b1;
        tick(4); timeout_clr = 1'b1; tick(1); timeout_clr = 1'b0;
        check("clr_vs_terminal", 32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1; tick(1); timeout_clr = 1'b0;
        check("clr_alone", 32'(timeout_flag), 32'd0);
        tick(2);
        cnt_en = 1'b0; tick(2);

        // reset pulse in the middle of a periodic run
        cnt_mode = 1'b1; cnt_en = 1'b1; tick(7);
        rst = 1'b1; tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_flag", 32'(timeout_flag), 32'd0);
        check("midrst_cnt", 32'(cnt_val), 32'd0);
        rst = 1'b0; tick(1);
        check("restart_after_rst", 32'(busy), 32'd1);
        tick(6);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            cnt_en      = ($urandom_range(0, 99) < 96);
            cnt_hold    = ($urandom_range(0, 99) < 15);
            timeout_clr = ($urandom_range(0, 99) < 6);
            cnt_sel     = SEL_W'($urandom);
            cnt_mode    = 1'($urandom);
            prescale    = PRESC_W'($urandom);
            tick(1);
        end

        rst = 1'b0; cnt_en = 1'b0; cnt_hold = 1'b0; timeout_clr = 1'b0;
        tick(5);
        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
